// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry fetch buffer, IF/ID register.
// Best case one instruction per 3 cycles; PCWrite/stall throttle requests, flush squashes and redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        PCWrite_i,
   input  logic        IFIDStall_i,
   input  logic        IFIDFlush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_IFID_o,
   output logic [31:0] instr_IFID_o,
   output logic        valid_IFID_o,
   output logic        fetch_busy_o
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_r, pc_nxt;
   logic [31:0] req_pc, req_pc_nxt;
   logic [31:0] fb_pc, fb_pc_nxt;
   logic [31:0] fb_instr, fb_instr_nxt;
   logic        fb_valid, fb_valid_nxt;
   logic [31:0] ifid_pc_nxt, ifid_instr_nxt;
   logic        ifid_valid_nxt;
   logic        handshake;

   // Reset gating keeps the request and busy flags low while rst_i is held.
   assign imem_req_o   = (state == S_REQ) & PCWrite_i & ~fb_valid & ~IFIDFlush_i & ~rst_i;
   assign imem_addr_o  = pc_r;
   assign fetch_busy_o = ((state == S_WAIT) | (state == S_DROP)) & ~rst_i;
   assign handshake    = imem_req_o & imem_gnt_i;

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc_r;
      req_pc_nxt     = req_pc;
      fb_pc_nxt      = fb_pc;
      fb_instr_nxt   = fb_instr;
      fb_valid_nxt   = fb_valid;
      ifid_pc_nxt    = pc_IFID_o;
      ifid_instr_nxt = instr_IFID_o;
      ifid_valid_nxt = valid_IFID_o;

      // Drain the fetch buffer into IF/ID, or insert a bubble when empty.
      if (!IFIDStall_i && !IFIDFlush_i) begin
         if (fb_valid) begin
            ifid_pc_nxt    = fb_pc;
            ifid_instr_nxt = fb_instr;
            ifid_valid_nxt = 1'b1;
            fb_valid_nxt   = 1'b0;
         end else begin
            ifid_pc_nxt    = 32'h0;
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
         end
      end

      case (state)
         S_IDLE: begin
            if (start_i) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (handshake) begin
               req_pc_nxt = pc_r;
               pc_nxt     = pc_r + 32'd4;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               state_nxt = S_REQ;
               if (!IFIDFlush_i) begin
                  fb_pc_nxt    = req_pc;
                  fb_instr_nxt = imem_rdata_i;
                  fb_valid_nxt = 1'b1;
               end
            end else if (IFIDFlush_i) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i) state_nxt = S_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Flush wins over stall and over any pc increment or buffer fill above.
      if (IFIDFlush_i) begin
         pc_nxt         = branch_target_i;
         fb_valid_nxt   = 1'b0;
         ifid_pc_nxt    = 32'h0;
         ifid_instr_nxt = NOP_INSTR;
         ifid_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         pc_r         <= RESET_PC;
         req_pc       <= 32'h0;
         fb_pc        <= 32'h0;
         fb_instr     <= NOP_INSTR;
         fb_valid     <= 1'b0;
         pc_IFID_o    <= 32'h0;
         instr_IFID_o <= NOP_INSTR;
         valid_IFID_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc_r         <= pc_nxt;
         req_pc       <= req_pc_nxt;
         fb_pc        <= fb_pc_nxt;
         fb_instr     <= fb_instr_nxt;
         fb_valid     <= fb_valid_nxt;
         pc_IFID_o    <= ifid_pc_nxt;
         instr_IFID_o <= ifid_instr_nxt;
         valid_IFID_o <= ifid_valid_nxt;
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 start_i  input  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-005 PCWrite_i  input  1  from hazard detection; 0 blocks new fetch requests.
REQ-006 IFIDStall_i  input  1  from hazard detection; 1 holds IF/ID outputs.
REQ-007 IFIDFlush_i  input  1  from hazard detection; 1 squashes IF/ID and redirects PC.
REQ-008 branch_target_i  input  32  redirect PC, sampled when IFIDFlush_i=1.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  32  request address, equals pc_r.
REQ-011 imem_gnt_i  input  1  request accepted; valid only when imem_req_o=1.
REQ-012 imem_rvalid_i  input  1  read data valid, earliest 1 cycle after grant.
REQ-013 imem_rdata_i  input  32  instruction word.
REQ-014 pc_IFID_o  output  32  IF/ID register: PC of instruction.
REQ-015 instr_IFID_o  output  32  IF/ID register: instruction.
REQ-016 valid_IFID_o  output  1  IF/ID register: 1 = real instruction, 0 = bubble.
REQ-017 fetch_busy_o  output  1  1 while a granted request is outstanding (WAIT or DROP).

Function
REQ-018 States: IDLE, REQ, WAIT, DROP; IDLE->REQ on start_i=1.
REQ-019 Internal: pc_r, req_pc (address of outstanding request), one-entry fetch buffer fb_pc/fb_instr/fb_valid.
REQ-020 imem_req_o = (state==REQ) & PCWrite_i & ~fb_valid & ~IFIDFlush_i; combinational.
REQ-021 REQ: on imem_req_o & imem_gnt_i: req_pc<=pc_r, pc_r<=pc_r+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), ->WAIT.
REQ-022 WAIT: on imem_rvalid_i: fb_pc<=req_pc, fb_instr<=imem_rdata_i, fb_valid<=1, ->REQ.
REQ-023 DROP: on imem_rvalid_i: data discarded, fb unchanged, ->REQ.
REQ-024 imem_rvalid_i in IDLE or REQ ignored.
REQ-025 At most one outstanding request; no request issued in WAIT/DROP.
REQ-026 IF/ID update when IFIDStall_i=0 and IFIDFlush_i=0: fb_valid=1 -> load fb_pc/fb_instr, valid=1, fb_valid<=0; fb_valid=0 -> load pc=0, instr=32'h0000_0013, valid=0.
REQ-027 IFIDStall_i=1 and IFIDFlush_i=0: IF/ID outputs and fb held; fetch still fills empty fb if PCWrite_i=1.
REQ-028 IFIDFlush_i=1 (priority over stall): IF/ID <= pc 0, instr 32'h0000_0013, valid 0; fb_valid<=0; pc_r<=branch_target_i.
REQ-029 Flush in WAIT without imem_rvalid_i: ->DROP; flush in WAIT with imem_rvalid_i same cycle: data discarded, ->REQ.
REQ-030 Flush in DROP stays DROP (or ->REQ if imem_rvalid_i same cycle); flush in REQ stays REQ; flush in IDLE updates pc_r only.
REQ-031 Flush overrides REQ-021 pc_r increment (no grant possible since imem_req_o=0).
REQ-032 Best-case latency: req/gnt cycle N, rvalid N+1, fb valid after edge N+1, IF/ID valid after edge N+2.
REQ-033 fetch_busy_o = (state==WAIT)|(state==DROP).

Reset
REQ-034 rst_i=1 at edge: state IDLE, pc_r=RESET_PC, req_pc=0, fb_valid=0, pc_IFID_o=0, instr_IFID_o=32'h0000_0013, valid_IFID_o=0; imem_req_o=0, fetch_busy_o=0 during and after.
REQ-035 Reset mid-request: outstanding request abandoned; later imem_rvalid_i ignored per REQ-024.
REQ-036 rst_i overrides start_i and all other inputs in the same cycle.

Verification
REQ-037 Reset, start_i, memory gnt same cycle, rvalid +1, stall/flush 0 -> addresses 0,4,8; IF/ID shows pc 0,4,8 valid=1, one instruction per 3 cycles.
REQ-038 IFIDStall_i=1, PCWrite_i=0 for 3 cycles with fb full -> IF/ID and fb unchanged, imem_req_o=0; release -> buffered instr enters IF/ID next edge.
REQ-039 Flush with branch_target_i=0x100 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never in IF/ID; next request address 0x100.
REQ-040 Flush and imem_rvalid_i same cycle in WAIT -> data dropped, state REQ, next address = branch_target_i.
REQ-041 IFIDStall_i=1 and IFIDFlush_i=1 together -> IF/ID becomes bubble (instr 0x13, valid 0).
REQ-042 RESET_PC=32'hFFFF_FFFC, one fetch -> second request address 0x0000_0000; rst_i asserted in WAIT then rvalid -> ignored, outputs at reset values.
